// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one async-write/async-read memory between two
// requesters, sequencing writes as setup / one-cycle write pulse / hold.
module mem_port_arbiter #(
    parameter int AW = 8,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic          ack0,
    output logic [DW-1:0] rdata0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          ack1,
    output logic [DW-1:0] rdata1,
    output logic [AW-1:0] mem_address,
    output logic [DW-1:0] mem_wd,
    output logic          mem_wen,
    input  logic [DW-1:0] mem_rd,
    output logic          busy,
    output logic [2:0]    state_dbg
);

    // Handshake: reqN is held with stable we/addr/wdata until ackN, a one-cycle
    // pulse; the requester drops reqN on the edge where it samples ackN high.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        W_SETUP = 3'd1,
        W_PULSE = 3'd2,
        W_HOLD  = 3'd3,
        R_SETUP = 3'd4,
        R_DONE  = 3'd5
    } state_t;

    state_t state;
    logic   winner;
    logic   last;

    logic          pick1;
    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;

    // With both requesting, the one that was not served last wins.
    assign pick1     = req1 && (!req0 || !last);
    assign sel_we    = pick1 ? we1    : we0;
    assign sel_addr  = pick1 ? addr1  : addr0;
    assign sel_wdata = pick1 ? wdata1 : wdata0;

    assign busy      = (state != IDLE);
    assign state_dbg = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            winner      <= 1'b0;
            last        <= 1'b1;
            mem_address <= '0;
            mem_wd      <= '0;
            mem_wen     <= 1'b0;
            ack0        <= 1'b0;
            ack1        <= 1'b0;
            rdata0      <= '0;
            rdata1      <= '0;
        end else begin
            ack0    <= 1'b0;
            ack1    <= 1'b0;
            mem_wen <= 1'b0;
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        winner      <= pick1;
                        last        <= pick1;
                        mem_address <= sel_addr;
                        if (sel_we) begin
                            mem_wd <= sel_wdata;
                            state  <= W_SETUP;
                        end else begin
                            state  <= R_SETUP;
                        end
                    end
                end
                W_SETUP: begin
                    mem_wen <= 1'b1;
                    state   <= W_PULSE;
                end
                W_PULSE: begin
                    if (winner) ack1 <= 1'b1;
                    else        ack0 <= 1'b1;
                    state <= W_HOLD;
                end
                W_HOLD: state <= IDLE;
                R_SETUP: begin
                    // Address has been stable a full cycle, so mem_rd has settled.
                    if (winner) begin
                        rdata1 <= mem_rd;
                        ack1   <= 1'b1;
                    end else begin
                        rdata0 <= mem_rd;
                        ack0   <= 1'b1;
                    end
                    state <= R_DONE;
                end
                R_DONE:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural async memory and an
// ack scoreboard holding expected {id, we, data} per transaction.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
    logic [7:0]  addr0 = '0, addr1 = '0;
    logic [15:0] wdata0 = '0, wdata1 = '0;
    logic        ack0, ack1, mem_wen, busy;
    logic [15:0] rdata0, rdata1, mem_wd, mem_rd;
    logic [7:0]  mem_address;
    logic [2:0]  state_dbg;

    logic [15:0] tb_mem [256];
    logic [17:0] exp_q[$];
    int          n_assert = 0;
    int          n_fail   = 0;
    logic        prev_wen = 1'b0;

    mem_port_arbiter #(.AW(8), .DW(16)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
        .mem_address(mem_address), .mem_wd(mem_wd), .mem_wen(mem_wen), .mem_rd(mem_rd),
        .busy(busy), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    // Memory writes whenever its enable is high; read is combinational.
    always @* if (mem_wen) tb_mem[mem_address] = mem_wd;
    assign mem_rd = tb_mem[mem_address];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int id, input logic r, input logic w,
                         input logic [7:0] a, input logic [15:0] d);
        if (id == 0) begin req0 = r; we0 = w; addr0 = a; wdata0 = d; end
        else         begin req1 = r; we1 = w; addr1 = a; wdata1 = d; end
    endtask

    // Waits for ackN (bounded), then drops reqN just after the edge that sampled it.
    task automatic wait_ack(input int id, output int lat);
        logic seen;
        seen = 1'b0;
        lat  = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            lat++;
            seen = (id == 0) ? ack0 : ack1;
        end
        chk($sformatf("ack%0d_timeout", id), seen, 1'b1);
        @(posedge clk);
        #1;
        if (id == 0) req0 = 1'b0;
        else         req1 = 1'b0;
    endtask

    task automatic req_txn(input int id, input logic w, input logic [7:0] a,
                           input logic [15:0] d, output int lat);
        drive(id, 1'b1, w, a, d);
        wait_ack(id, lat);
    endtask

    // Monitor: ack exclusivity, pulse width, and scoreboard pops on each ack.
    always @(negedge clk) begin
        if (!rst) begin
            chk("dual_ack", ack0 && ack1, 1'b0);
            chk("wen_width", mem_wen && prev_wen, 1'b0);
            if (mem_wen) chk("wen_state", state_dbg, 3'd2);
            if (ack0 || ack1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_ack", {ack1, ack0}, 2'b00);
                end else begin
                    logic [17:0] e;
                    e = exp_q.pop_front();
                    chk("ack_id", ack1, e[17]);
                    if (!e[16]) chk("rdata", ack1 ? rdata1 : rdata0, e[15:0]);
                end
            end
        end
        prev_wen <= mem_wen;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int l0;
        int l1;

        // Reset state
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wen_async", mem_wen, 1'b0);
        rst = 1'b0;
        sync();
        chk("rst_state", state_dbg, 3'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_addr", mem_address, 8'h00);
        chk("rst_wd", mem_wd, 16'h0000);
        chk("rst_ack", {ack1, ack0}, 2'b00);
        chk("rst_rdata0", rdata0, 16'h0000);
        chk("rst_rdata1", rdata1, 16'h0000);

        // Write 0x12 <= 0xBEEF, cycle by cycle
        drive(0, 1'b1, 1'b1, 8'h12, 16'hBEEF);
        exp_q.push_back({1'b0, 1'b1, 16'hBEEF});
        @(posedge clk);
        @(negedge clk);
        chk("w1_busy", busy, 1'b1);
        chk("w1_wen", mem_wen, 1'b0);
        chk("w1_addr", mem_address, 8'h12);
        chk("w1_ack", ack0, 1'b0);
        @(negedge clk);
        chk("w2_wen", mem_wen, 1'b1);
        chk("w2_addr", mem_address, 8'h12);
        chk("w2_wd", mem_wd, 16'hBEEF);
        chk("w2_busy", busy, 1'b1);
        @(negedge clk);
        chk("w3_ack", ack0, 1'b1);
        chk("w3_wen", mem_wen, 1'b0);
        chk("w3_busy", busy, 1'b1);
        @(posedge clk);
        #1;
        req0 = 1'b0;
        @(negedge clk);
        chk("w4_busy", busy, 1'b0);
        chk("w4_ack", ack0, 1'b0);
        chk("mem_12", tb_mem[8'h12], 16'hBEEF);

        // Requester 1 reads it back; ack on the 2nd cycle after grant
        sync();
        exp_q.push_back({1'b1, 1'b0, 16'hBEEF});
        req_txn(1, 1'b0, 8'h12, 16'h0000, lat);
        chk("rd_latency", lat, 3);
        chk("rdata1_beef", rdata1, 16'hBEEF);
        chk("rdata0_held", rdata0, 16'h0000);

        // Both request from reset: requester 0 first
        rst = 1'b1;
        sync();
        rst = 1'b0;
        sync();
        exp_q.push_back({1'b0, 1'b1, 16'hAAAA});
        exp_q.push_back({1'b1, 1'b1, 16'h5555});
        fork
            req_txn(0, 1'b1, 8'h01, 16'hAAAA, l0);
            req_txn(1, 1'b1, 8'h02, 16'h5555, l1);
        join
        chk("both_lat0", l0, 4);
        exp_q.push_back({1'b0, 1'b0, 16'hAAAA});
        req_txn(0, 1'b0, 8'h01, 16'h0000, lat);
        exp_q.push_back({1'b1, 1'b0, 16'h5555});
        req_txn(1, 1'b0, 8'h02, 16'h0000, lat);
        chk("rdata0_after_r1", rdata0, 16'hAAAA);

        // Back-to-back with both holding req: grants alternate
        sync();
        for (int k = 0; k < 6; k++)
            exp_q.push_back({1'(k % 2), 1'b1, 16'(16'h6000 + k)});
        fork
            begin
                int la;
                for (int k = 0; k < 3; k++)
                    req_txn(0, 1'b1, 8'(8'h40 + 2 * k), 16'(16'h6000 + 2 * k), la);
            end
            begin
                int lb;
                for (int k = 0; k < 3; k++)
                    req_txn(1, 1'b1, 8'(8'h41 + 2 * k), 16'(16'h6001 + 2 * k), lb);
            end
        join
        chk("b2b_mem44", tb_mem[8'h44], 16'h6004);
        chk("b2b_mem45", tb_mem[8'h45], 16'h6005);

        // Inputs changed after grant have no effect
        sync();
        drive(0, 1'b1, 1'b1, 8'h20, 16'h1234);
        exp_q.push_back({1'b0, 1'b1, 16'h1234});
        @(posedge clk);
        #1;
        addr0  = 8'h21;
        wdata0 = 16'hDEAD;
        wait_ack(0, lat);
        chk("late_mem20", tb_mem[8'h20], 16'h1234);
        chk("late_mem21_untouched", tb_mem[8'h21] == 16'hDEAD, 1'b0);

        // Reset during W_SETUP abandons the write
        sync();
        exp_q.push_back({1'b0, 1'b1, 16'h0777});
        req_txn(0, 1'b1, 8'h30, 16'h0777, lat);
        sync();
        drive(0, 1'b1, 1'b1, 8'h30, 16'h9999);
        @(posedge clk);
        @(negedge clk);
        chk("abort_in_setup", state_dbg, 3'd1);
        rst = 1'b1;
        #1;
        chk("abort_wen", mem_wen, 1'b0);
        chk("abort_state", state_dbg, 3'd0);
        chk("abort_ack", {ack1, ack0}, 2'b00);
        req0 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("abort_wen_hold", mem_wen, 1'b0);
        rst = 1'b0;
        sync();
        chk("abort_mem30", tb_mem[8'h30], 16'h0777);
        exp_q.push_back({1'b0, 1'b0, 16'h0777});
        exp_q.push_back({1'b1, 1'b0, 16'h0777});
        fork
            req_txn(0, 1'b0, 8'h30, 16'h0000, l0);
            req_txn(1, 1'b0, 8'h30, 16'h0000, l1);
        join
        chk("post_rst_favour0", l0 < l1, 1'b1);

        repeat (3) @(posedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Two-requester controller that shares one asynchronous-write/asynchronous-read 256x16 memory between two clients.
- Arbitrates round-robin and sequences each access as a clean setup / write-pulse / hold sequence, because the memory writes whenever its write enable is high.
- Captures read data into per-requester registers.
- Sits between two bus clients and the memory instance.

Parameters:
- AW, 8, address width (memory depth 2**AW).
- DW, 16, data width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- req0  in  1  requester 0 access request; held until ack0.
- we0  in  1  requester 0: 1 = write, 0 = read; stable while req0 is high.
- addr0  in  AW  requester 0 address.
- wdata0  in  DW  requester 0 write data.
- ack0  out  1  one-cycle completion pulse to requester 0.
- rdata0  out  DW  requester 0 read data register.
- req1, we1, addr1, wdata1, ack1, rdata1: same as above, for requester 1.
- mem_address  out  AW  memory address, registered.
- mem_wd  out  DW  memory write data, registered.
- mem_wen  out  1  memory write enable, registered.
- mem_rd  in  DW  memory read data (combinational from mem_address).
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (async, rst=1): state=IDLE; mem_address=0, mem_wd=0, mem_wen=0; ack0=ack1=0; rdata0=rdata1=0; busy=0; round-robin pointer last=1, so requester 0 wins first.
- States: IDLE, W_SETUP, W_PULSE, W_HOLD, R_SETUP, R_DONE. All outputs come from registers or decode of the state register.
- IDLE: arbitration happens only here, one grant per transaction.
  - Single request: that requester wins.
  - Both requesting: the requester != last wins.
  - At the grant edge: register the winner's addr into mem_address, wdata into mem_wd (writes only; mem_wd is unchanged on reads), the winner id, and update last=winner. Next state is W_SETUP if we=1, else R_SETUP.
  - No request: stay in IDLE; mem_address and mem_wd hold their previous values.
- Write path:
  - W_SETUP: mem_wen=0, address/data stable.
  - W_PULSE: mem_wen=1 for exactly one cycle.
  - W_HOLD: mem_wen=0, address/data still stable, ack(winner)=1.
  - Then IDLE.
  - Write ack is high in the 3rd cycle after the grant edge.
- Read path:
  - R_SETUP: address stable, mem_wen=0.
  - At the edge leaving R_SETUP: rdata(winner) <= mem_rd.
  - R_DONE: ack(winner)=1.
  - Then IDLE.
  - Read ack is high in the 2nd cycle after the grant edge.
- rdataN changes only at a read capture for requester N; otherwise it holds, including across the other requester's accesses and across N's writes.
- mem_wen is never high outside W_PULSE. mem_address and mem_wd never change while mem_wen=1 or in the cycle before or after it.
- Requester protocol:
  - Deassert req on the edge where ack is sampled high.
  - If req is still high in IDLE after ack, it is treated as a new request and re-arbitrated against the other requester.
- Inputs of the losing requester are ignored until it is granted. Changes to a requester's addr, we or wdata after its grant edge have no effect on the transaction in progress.
- Back-to-back with both requesters holding req: grants alternate 0,1,0,1,... Each transaction is followed by one IDLE cycle.
- Reset mid-operation: outputs go to reset values immediately, including mem_wen=0 asynchronously. The pending transaction is abandoned with no ack. The write may or may not have landed if reset hits during W_PULSE.
- Simultaneous ack0 and ack1 never occur.

Test Plan:
- Reset, then req0 write addr0=0x12 wdata0=0xBEEF -> mem_wen high exactly one cycle (2nd cycle after grant) with mem_address=0x12, mem_wd=0xBEEF; ack0 in the 3rd cycle; busy high for 3 cycles.
- After the above, req1 read addr1=0x12 -> ack1 in the 2nd cycle after grant, rdata1=0xBEEF; rdata0 unchanged at 0.
- req0 and req1 both asserted from reset (writes 0xAAAA to 0x01, 0x5555 to 0x02) -> requester 0 served first, then requester 1; reads back 0xAAAA / 0x5555.
- Both requesters hold req continuously for 6 transactions -> grant order 0,1,0,1,0,1; never two acks in one cycle; mem_wen pulses never wider than one cycle.
- Change addr0/wdata0 during W_SETUP -> memory written with the values sampled at grant only.
- Assert rst during W_SETUP of a write to 0x30 -> mem_wen stays 0, no ack, state IDLE. Subsequent read of 0x30 returns its pre-reset content, and the next arbitration favours requester 0.
